jzjpcc_mmio_input_conditioner: RTL and testbench
================================================

Name: jzjpcc_mmio_input_conditioner

Overview:
Conditions raw asynchronous external inputs (switches, buttons, test pins) before they drive an MMIO input word of the core (mmioInputs[n]).
- Synchronises the whole word into the core clock domain and debounces it as a unit.
- Publishes the stable word, a one-cycle change pulse, sticky per-bit rising-edge flags that software clears, and a wrapping change counter.
- One instance per conditioned MMIO input word; instantiated in top between the pins and jzjpcc.

Parameters:
WIDTH, 32, width of the raw and conditioned word.
SYNC_STAGES, 2, number of synchroniser flops (>=2).
DEBOUNCE_CYCLES, 1000, consecutive clock cycles the synchronised word must be unchanged before it is accepted (>=1).
COUNT_WIDTH, 16, width of the change counter.

Ports:
clock  input  1  core clock; all state updates on its rising edge.
reset  input  1  asynchronous, active-high reset.
rawIn  input  WIDTH  unsynchronised external input word.
clearFlags  input  WIDTH  per-bit clear mask for risingFlags; sampled each cycle.
stableValue  output  WIDTH  debounced word, fed to mmioInputs.
changePulse  output  1  high for exactly one cycle after stableValue takes a new, different value.
risingFlags  output  WIDTH  sticky flags: bit i set when stableValue[i] goes 0->1.
changeCount  output  COUNT_WIDTH  number of accepted changes, wraps modulo 2^COUNT_WIDTH.

Behaviour:
- Reset (async assert, any time, including mid-debounce): all synchroniser stages, the candidate register, the debounce counter, stableValue, changePulse, risingFlags and changeCount go to 0 immediately. After reset release, the first edge resumes normal operation.
- Synchroniser: sync[0] <= rawIn and sync[k] <= sync[k-1] each cycle. The synchronised word is syncOut = sync[SYNC_STAGES-1].
- Debounce: candidate register cand plus counter cnt of width clog2(DEBOUNCE_CYCLES+1). Priority each edge:
  1. syncOut != cand: cand <= syncOut, cnt <= 0.
  2. Else if cnt == DEBOUNCE_CYCLES-1: stableValue <= cand, cnt <= DEBOUNCE_CYCLES (done marker).
  3. Else if cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  4. Else (cnt == DEBOUNCE_CYCLES): hold; cnt saturates, no further writes.
- Any bit toggling in syncOut restarts the whole word's timer (word-level debounce).
- Latency: a rawIn change held steady is visible on stableValue after rising edge number SYNC_STAGES+DEBOUNCE_CYCLES+1, counting the first edge after the change as 1.
- Bounce returning to the old value: stableValue is rewritten with an identical value. There is no pulse, no count increment and no flag change.
- changePulse: registered. It is 1 in the cycle after the edge where stableValue was written with a value != its previous value; otherwise 0. It is never high for two consecutive cycles.
- changeCount: increments by 1 on the same edge that sets changePulse. Wraps from all-ones to 0.
- risingFlags: on each edge, risingFlags <= (risingFlags & ~clearFlags) | rise, where rise = newStable & ~oldStable on an accepted change, else 0. Set wins over a simultaneous clear on the same bit.
- Falling edges never set flags.
- No combinational path from any input to any output.

Test Plan:
(Bench parameters: WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_WIDTH=4.)
- Reset, then rawIn=8'hA5 held steady -> stableValue=8'h00 through edge 6; stableValue=8'hA5 after edge 7; changePulse=1 for one cycle; changeCount=1; risingFlags=8'hA5.
- From stable 8'hA5, rawIn glitches to 8'hA4 for 2 cycles then returns -> stableValue stays 8'hA5; changePulse never asserts; changeCount stays 1.
- From stable 8'h00, rawIn=8'h01 toggling every 3 cycles for 20 cycles, then held at 8'h01 -> no update during toggling; stableValue=8'h01 on the 7th edge after the final transition; exactly one pulse.
- With risingFlags=8'h0F, drive clearFlags=8'h03 for one cycle -> risingFlags=8'h0C. Clear bit 4 on the same edge an accepted 0->1 on bit 4 lands -> bit 4 reads 1.
- 17 accepted alternating changes (8'h00<->8'hFF) -> changeCount wraps from 4'hF to 4'h0 to 4'h1; one pulse per change.
- Assert reset asynchronously mid-debounce (cnt=2) and mid-pulse -> all outputs 0 before the next clock edge; after release with rawIn steady, full 7-edge latency applies again.

Source files
------------

// File: rtl/jzjpcc_mmio_input_conditioner.sv
// MMIO input conditioner: synchronise, word-debounce and publish
// a raw external input word with change pulse, rise flags and count.
module jzjpcc_mmio_input_conditioner #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       rawIn,
  input  logic [WIDTH-1:0]       clearFlags,
  output logic [WIDTH-1:0]       stableValue,
  output logic                   changePulse,
  output logic [WIDTH-1:0]       risingFlags,
  output logic [COUNT_WIDTH-1:0] changeCount
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0]       sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       sync_out;

  logic [WIDTH-1:0]       cand_q,   cand_d;
  logic [CNT_W-1:0]       cnt_q,    cnt_d;
  logic [WIDTH-1:0]       stable_q, stable_d;
  logic                   pulse_q,  pulse_d;
  logic [WIDTH-1:0]       flags_q,  flags_d;
  logic [COUNT_WIDTH-1:0] count_q,  count_d;

  logic                   accept;
  logic                   changed;
  logic [WIDTH-1:0]       rise;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the raw word through the synchroniser chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= rawIn;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Word-level debounce: any bit change restarts the timer;
  // the counter parks at CNT_DONE once the candidate is accepted.
  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    accept = 1'b0;
    if (sync_out != cand_q) begin
      cand_d = sync_out;
      cnt_d  = '0;
    end else if (cnt_q == CNT_LAST) begin
      accept = 1'b1;
      cnt_d  = CNT_DONE;
    end else if (cnt_q < CNT_LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Derive published state; an identical rewrite is invisible.
  always_comb begin
    changed  = accept && (cand_q != stable_q);
    rise     = changed ? (cand_q & ~stable_q) : '0;
    stable_d = accept ? cand_q : stable_q;
    pulse_d  = changed;
    flags_d  = (flags_q & ~clearFlags) | rise;
    count_d  = count_q + COUNT_WIDTH'(changed);
  end

  // Register debounce and output state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      pulse_q  <= 1'b0;
      flags_q  <= '0;
      count_q  <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  assign stableValue = stable_q;
  assign changePulse = pulse_q;
  assign risingFlags = flags_q;
  assign changeCount = count_q;

endmodule

// File: tb/tb_jzjpcc_mmio_input_conditioner.sv
// Self-checking bench for jzjpcc_mmio_input_conditioner with a
// run-length reference model and randomized stimulus.
module tb_jzjpcc_mmio_input_conditioner;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int D  = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  rawIn = '0;
  logic [W-1:0]  clearFlags = '0;
  logic [W-1:0]  stableValue;
  logic          changePulse;
  logic [W-1:0]  risingFlags;
  logic [CW-1:0] changeCount;

  int total = 0;
  int bad   = 0;
  int dut_pulses = 0;

  // reference model state
  logic [W-1:0]  hist [$];
  logic [W-1:0]  run_val;
  int            run_len;
  logic [W-1:0]  m_stable;
  logic          m_pulse;
  logic [W-1:0]  m_flags;
  int            m_count;

  jzjpcc_mmio_input_conditioner #(
    .WIDTH(W), .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .rawIn(rawIn), .clearFlags(clearFlags),
    .stableValue(stableValue), .changePulse(changePulse),
    .risingFlags(risingFlags), .changeCount(changeCount)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S; i++) hist.push_back('0);
    // after reset the candidate already equals syncOut: one free match
    run_val  = '0;
    run_len  = 1;
    m_stable = '0;
    m_pulse  = 1'b0;
    m_flags  = '0;
    m_count  = 0;
  endtask

  // One rising edge: syncOut seen now is rawIn from S edges ago.
  // A value is accepted when it has been seen on D+1 consecutive edges.
  task automatic model_step(input logic [W-1:0] raw,
                            input logic [W-1:0] clr);
    logic [W-1:0] s;
    logic         chg;
    logic [W-1:0] rise;
    s = hist.pop_front();
    hist.push_back(raw);
    if (s == run_val) begin
      if (run_len <= D + 1) run_len++;
    end else begin
      run_val = s;
      run_len = 1;
    end
    chg  = (run_len == D + 1) && (run_val != m_stable);
    rise = chg ? (run_val & ~m_stable) : '0;
    m_flags = (m_flags & ~clr) | rise;
    if (run_len == D + 1) m_stable = run_val;
    m_pulse = chg;
    if (chg) m_count = (m_count + 1) % (1 << CW);
  endtask

  task automatic compare();
    check("stableValue", 32'(stableValue), 32'(m_stable));
    check("changePulse", 32'(changePulse), 32'(m_pulse));
    check("risingFlags", 32'(risingFlags), 32'(m_flags));
    check("changeCount", 32'(changeCount), 32'(m_count));
  endtask

  // Advance one cycle: step model at the edge, compare at negedge.
  task automatic tick();
    @(posedge clock);
    model_step(rawIn, clearFlags);
    @(negedge clock);
    dut_pulses += int'(changePulse);
    compare();
  endtask

  // Called at a negedge: asynchronous assert, check, release.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_stable", 32'(stableValue), 32'h0);
    check("rst_pulse",  32'(changePulse), 32'h0);
    check("rst_flags",  32'(risingFlags), 32'h0);
    check("rst_count",  32'(changeCount), 32'h0);
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int hold;
    int p0;
    model_reset();
    @(negedge clock);
    apply_reset();

    // steady A5 after reset: 7-edge latency
    rawIn = 8'hA5;
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("lat_hold", 32'(stableValue), 32'h00);
    end
    tick();
    check("lat_val",   32'(stableValue), 32'hA5);
    check("lat_pulse", 32'(changePulse), 32'h1);
    check("lat_count", 32'(changeCount), 32'h1);
    check("lat_flags", 32'(risingFlags), 32'hA5);
    tick();
    check("pulse_once", 32'(changePulse), 32'h0);

    // two-cycle glitch returns to A5
    p0 = dut_pulses;
    rawIn = 8'hA4;
    tick(); tick();
    rawIn = 8'hA5;
    for (int i = 0; i < 15; i++) tick();
    check("glitch_val",   32'(stableValue), 32'hA5);
    check("glitch_count", 32'(changeCount), 32'h1);
    check("glitch_pulse", 32'(dut_pulses - p0), 32'h0);

    // settle to 00, then toggle every 3 cycles
    rawIn = 8'h00;
    for (int i = 0; i < 10; i++) tick();
    check("fall_val",   32'(stableValue), 32'h00);
    check("fall_flags", 32'(risingFlags), 32'hA5);
    p0 = dut_pulses;
    for (int c = 0; c < 20; c++) begin
      rawIn = ((c / 3) % 2 == 0) ? 8'h01 : 8'h00;
      tick();
    end
    check("tog_none", 32'(stableValue), 32'h00);
    for (int e = 3; e <= 6; e++) begin
      tick();
      check("tog_hold", 32'(stableValue), 32'h00);
    end
    tick();
    check("tog_val", 32'(stableValue), 32'h01);
    for (int i = 0; i < 4; i++) tick();
    check("tog_pulses", 32'(dut_pulses - p0), 32'h1);

    // flag clearing and set-wins-over-clear
    apply_reset();
    rawIn = 8'h0F;
    for (int i = 0; i < 8; i++) tick();
    check("flags_0f", 32'(risingFlags), 32'h0F);
    clearFlags = 8'h03;
    tick();
    clearFlags = 8'h00;
    check("flags_0c", 32'(risingFlags), 32'h0C);
    rawIn = 8'h1F;
    clearFlags = 8'h10;
    for (int i = 0; i < 7; i++) tick();
    clearFlags = 8'h00;
    check("set_wins", 32'(risingFlags), 32'h1C);
    tick();

    // 17 alternating accepted changes: counter wraps
    apply_reset();
    p0 = dut_pulses;
    for (int k = 1; k <= 17; k++) begin
      rawIn = (k % 2 == 1) ? 8'hFF : 8'h00;
      for (int i = 0; i < 7; i++) tick();
      check("wrap_pulse", 32'(changePulse), 32'h1);
      check("wrap_count", 32'(changeCount), 32'(k % 16));
      tick();
    end
    check("wrap_pulses", 32'(dut_pulses - p0), 32'd17);

    // reset mid-debounce, then full latency again
    apply_reset();
    rawIn = 8'h33;
    for (int i = 0; i < 5; i++) tick();
    apply_reset();
    for (int e = 1; e <= 6; e++) begin
      tick();
      check("rlat_hold", 32'(stableValue), 32'h00);
    end
    tick();
    check("rlat_val", 32'(stableValue), 32'h33);
    check("rlat_pulse", 32'(changePulse), 32'h1);
    // reset while the pulse is high
    apply_reset();
    for (int i = 0; i < 3; i++) tick();

    // randomized: bursts of bit flips and sporadic clears
    hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        if ($urandom_range(0, 2) == 0)
          rawIn = W'($urandom);
        else
          rawIn = rawIn ^ (W'(1) << $urandom_range(0, W - 1));
        hold = $urandom_range(1, 9);
      end
      hold--;
      clearFlags = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
      tick();
    end
    clearFlags = '0;
    for (int i = 0; i < 10; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
